// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, credit-limited memory requests, in-order {pc, word} FIFO.
// Optional FETCH_BYPASS_EN: a response into an empty FIFO is shown on if_* in the same cycle.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        id_ready,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [31:0]   fifo_pc_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_d [FIFO_DEPTH];
   logic [31:0]   fifo_word_q [FIFO_DEPTH];
   logic [31:0]   fifo_word_d [FIFO_DEPTH];
   logic [31:0]   tag_q [FIFO_DEPTH];
   logic [31:0]   tag_d [FIFO_DEPTH];

   logic [CW:0] used;
   logic        accept;
   logic        rsp_keep;
   logic        head_valid;
   logic        bypass;
   logic        push;
   logic        pop;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Credits cover both buffered words and words still owed by memory.
   assign used           = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req_valid = reset_n && (used < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign head_valid     = (count_q != '0);

`ifdef FETCH_BYPASS_EN
   assign bypass = rsp_keep && !head_valid;
`else
   assign bypass = 1'b0;
`endif

   assign pop  = head_valid && id_ready;
   assign push = rsp_keep && !(bypass && id_ready);

   always_comb begin
      if_valid       = head_valid || bypass;
      if_pc          = 32'h0;
      if_instruction = 32'h0;
      if (head_valid) begin
         if_pc          = fifo_pc_q[rd_ptr_q];
         if_instruction = fifo_word_q[rd_ptr_q];
      end else if (bypass) begin
         if_pc          = tag_q[tag_rd_q];
         if_instruction = imem_rsp_data;
      end
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      tag_wr_d    = tag_wr_q;
      tag_rd_d    = tag_rd_q;
      fifo_pc_d   = fifo_pc_q;
      fifo_word_d = fifo_word_q;
      tag_d       = tag_q;
      drop_d      = drop_q;

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         if (!redirect_valid) begin
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_wr_q + PW'(1);
         end
      end
      if (rsp_keep) begin
         tag_rd_d = tag_rd_q + PW'(1);
      end
      if (push) begin
         fifo_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
         fifo_word_d[wr_ptr_q] = imem_rsp_data;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      // Everything still owed by memory after this edge belongs to the old path.
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
         drop_d     = inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_word_q[i] <= '0;
            tag_q[i]       <= '0;
         end
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tag_wr_q    <= tag_wr_d;
         tag_rd_q    <= tag_rd_d;
         fifo_pc_q   <= fifo_pc_d;
         fifo_word_q <= fifo_word_d;
         tag_q       <= tag_d;
      end
   end

   full_push_a: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-configurable memory model feeds the DUT and
// every word consumed by decode is checked against the in-order queue of expected fetch PCs.
module tb_fetch_stage;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .id_ready       (id_ready),
      .if_instruction (if_instruction),
      .if_pc          (if_pc)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   logic        mem_ready = 1'b1;
   int          n_acc = 0;
   int          pops = 0;
   logic [31:0] last_pop_pc = 32'h0;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_pc_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic drive_mem();
      imem_req_ready = mem_ready;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr_q[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   // One clock cycle: sample, score, advance memory model; returns just after the negedge.
   task automatic step();
      logic        acc, dec, redir;
      logic [31:0] a, e;
      drive_mem();
      #1;
      acc   = reset_n && imem_req_valid && imem_req_ready;
      a     = imem_req_addr;
      redir = reset_n && redirect_valid;
      dec   = reset_n && if_valid && id_ready;
      if (dec) begin
         checks++;
         if (exp_pc_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got pc %h instr %h, required no output",
                     if_pc, if_instruction);
         end else begin
            e = exp_pc_q.pop_front();
            if (if_pc !== e || if_instruction !== mem_word(e)) begin
               errors++;
               $display("FAIL scoreboard: got pc %h instr %h, required pc %h instr %h",
                        if_pc, if_instruction, e, mem_word(e));
            end
         end
         last_pop_pc = if_pc;
         pops++;
      end
      if (acc) begin
         checks++;
         if (a !== exp_addr) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", a, exp_addr);
         end
         exp_addr = exp_addr + 32'd4;
         n_acc++;
         if (!redir) exp_pc_q.push_back(a);
      end
      if (imem_rsp_valid) begin
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end
      if (redir) begin
         exp_pc_q.delete();
         exp_addr = {redirect_pc[31:2], 2'b00};
      end
      @(posedge clk);
      cyc++;
      if (acc) begin
         mem_addr_q.push_back(a);
         mem_due_q.push_back(cyc + mem_lat - 1);
      end
      @(negedge clk);
      drive_mem();
   endtask

   task automatic clear_models();
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_pc_q.delete();
      exp_addr = 32'h0;
      drive_mem();
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      mem_ready      = 1'b1;
      mem_lat        = 1;
      step();
      step();
      clear_models();
      reset_n = 1'b1;
   endtask

   task automatic wait_first_pop(input logic [31:0] want, input string name);
      int p0;
      bit seen;
      p0   = pops;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (pops != p0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no instruction within 30 cycles, required pc %h", name, want);
      end else if (last_pop_pc !== want) begin
         errors++;
         $display("FAIL %s: first pc %h, required %h", name, last_pop_pc, want);
      end
   endtask

   task automatic test_reset();
      int p0;
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b1;
      mem_ready      = 1'b1;
      mem_lat        = 1;
      step();
      step();
      clear_models();
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_req: got valid %b addr %h, required 0 00000000",
                  imem_req_valid, imem_req_addr);
      end
      checks++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin
         errors++;
         $display("FAIL reset_if: got valid %b pc %h instr %h, required 0 0 0",
                  if_valid, if_pc, if_instruction);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: got valid %b addr %h, required 1 00000000",
                  imem_req_valid, imem_req_addr);
      end
      p0 = pops;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (pops - p0 != 10) begin
         errors++;
         $display("FAIL throughput: got %0d instructions in 12 cycles, required 10", pops - p0);
      end
   endtask

   task automatic test_backpressure();
      int a0, p0;
      do_reset();
      a0 = n_acc;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (n_acc - a0 != 4) begin
         errors++;
         $display("FAIL credit_limit: got %0d requests, required 4", n_acc - a0);
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
         errors++;
         $display("FAIL stalled: got req_valid %b if_valid %b if_pc %h, required 0 1 00000000",
                  imem_req_valid, if_valid, if_pc);
      end
      id_ready = 1'b1;
      p0 = pops;
      a0 = n_acc;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (pops - p0 != 12) begin
         errors++;
         $display("FAIL drain: got %0d instructions in 12 cycles, required 12", pops - p0);
      end
      checks++;
      if (n_acc - a0 == 0) begin
         errors++;
         $display("FAIL resume: got 0 requests after release, required more than 0");
      end
   endtask

   task automatic test_redirect_stale();
      do_reset();
      mem_lat  = 3;
      id_ready = 1'b1;
      step();
      step();
      mem_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
      mem_ready      = 1'b1;
      #1;
      checks++;
      if (imem_req_addr !== 32'h0000_0100 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_next: got addr %h if_valid %b, required 00000100 0",
                  imem_req_addr, if_valid);
      end
      wait_first_pop(32'h0000_0100, "redirect_stale");
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_redirect_collision();
      do_reset();
      mem_lat  = 1;
      id_ready = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_addr !== 32'h0000_0040 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL collision_next: got addr %h if_valid %b, required 00000040 0",
                  imem_req_addr, if_valid);
      end
      wait_first_pop(32'h0000_0040, "redirect_collision");
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_wrap();
      do_reset();
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFD;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_start: got addr %h, required fffffffc", imem_req_addr);
      end
      step();
      #1;
      checks++;
      if (imem_req_addr !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap: got addr %h, required 00000000", imem_req_addr);
      end
      wait_first_pop(32'hFFFF_FFFC, "wrap_first");
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #1;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
         errors++;
         $display("FAIL pre_reset: got if_valid %b if_pc %h, required 1 00000000",
                  if_valid, if_pc);
      end
      reset_n = 1'b0;
      step();
      #1;
      checks++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got if_valid %b req_valid %b, required 0 0",
                  if_valid, imem_req_valid);
      end
      step();
      clear_models();
      reset_n = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL post_reset_req: got valid %b addr %h, required 1 00000000",
                  imem_req_valid, imem_req_addr);
      end
      id_ready = 1'b1;
      wait_first_pop(32'h0, "post_reset_first");
   endtask

   task automatic test_back_to_back();
      int p0;
      do_reset();
      mem_lat = 2;
      p0 = pops;
      for (int i = 0; i < 400; i++) begin
         mem_ready      = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = $urandom();
         step();
      end
      redirect_valid = 1'b0;
      checks++;
      if (pops - p0 < 50) begin
         errors++;
         $display("FAIL random_progress: got %0d instructions, required at least 50", pops - p0);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      @(negedge clk);
      test_reset();
      test_backpressure();
      test_redirect_stale();
      test_redirect_collision();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the RV32I pipeline: owns the program counter, issues word fetches to instruction memory, buffers returned words in a small in-order FIFO and presents `{pc, instruction}` to the decode/control stage through a valid/ready handshake. A taken branch, JAL or JALR resolved downstream redirects it. On redirect it flushes the FIFO and discards in-flight responses without stalling the memory port.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: fetch-buffer entries, power of two, 2..16. Also bounds in-flight requests.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address. Bits [1:0] are always 0.
- `imem_rsp_valid`  in  1  response word valid. Responses arrive in request order, with latency ≥1 cycle, and are never back-pressured.
- `imem_rsp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  control-flow redirect from execute.
- `redirect_pc`  in  32  redirect target. Bits [1:0] are ignored and treated as 0.
- `if_valid`  out  1  `if_instruction`/`if_pc` valid toward decode.
- `id_ready`  in  1  decode consumes this cycle.
- `if_instruction`  out  32  instruction word.
- `if_pc`  out  32  address of `if_instruction`.

## Operation
- State:
  - `fetch_pc` (next request address).
  - FIFO of `{pc, word}` with `count`.
  - `inflight` counter: accepted requests not yet answered, including ones to be dropped.
  - `drop` counter.
  - Counter width is clog2(FIFO_DEPTH+1).
- Issue: `imem_req_valid = (count + inflight < FIFO_DEPTH)`. `imem_req_addr = fetch_pc`.
  - Accept = `imem_req_valid && imem_req_ready`.
  - On accept: `fetch_pc += 4`, wrapping modulo 2^32.
  - The request PC is pushed to a PC tag queue of the same depth.
- Address change: the memory port tolerates the address changing while ready is low. On redirect the pending request address changes to the new target without an accept.
- Response handling:
  - If `drop > 0`: the word is discarded, and `drop` and `inflight` decrement.
  - Otherwise the word is pushed to the FIFO with the head PC tag, and `inflight` decrements.
- Decode side:
  - `if_valid = (count != 0)`.
  - The outputs show the FIFO head.
  - Pop on `if_valid && id_ready`.
- Redirect (highest priority), at the next edge:
  - FIFO flushed and `count = 0`.
  - PC tag queue cleared.
  - `fetch_pc = {redirect_pc[31:2], 2'b00}`.
  - `drop = inflight + accept_this_cycle − rsp_this_cycle`.
  - `inflight` is updated normally.
- Simultaneous events in the redirect cycle:
  - A response in that cycle is dropped.
  - A request accepted in that cycle counts toward `drop`.
  - A decode pop in that cycle completes; the flush removes everything else.
- Full FIFO: the credit rule guarantees every non-dropped response has a slot. A push into a full FIFO is an assertion failure.
- A push and a pop in the same cycle leave `count` unchanged.

## Timing
- Reset values:
  - `imem_req_valid = 0`, `imem_req_addr = RESET_PC`.
  - `if_valid = 0`, `if_instruction = 0`, `if_pc = 0`.
  - `fetch_pc = RESET_PC`.
  - `count = inflight = drop = 0`.
- First cycle after `reset_n` rises: `imem_req_valid = 1` with address `RESET_PC`.
- Throughput: one request per cycle while credits remain.
- Response to `if_valid`: a response at edge N sets `if_valid` from cycle N+1 (registered FIFO).
- Redirect at edge N: the request address equals the target at cycle N+1, and `if_valid = 0` at cycle N+1.
- Assertion of `reset_n` low mid-operation clears all state at the next edge. Responses arriving after reset for pre-reset requests are not tracked; memory must be reset together with this block.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty, a non-dropped response is presented combinationally on `if_*` in the same cycle.
  - If `id_ready` is high that cycle, the word is consumed without entering the FIFO; otherwise it is pushed.
  - Response-to-decode latency is 0 cycles.
  - Redirect still forces `if_valid = 0` in the redirect cycle for bypassed words.
- Undefined: there is no bypass path and latency is exactly 1 cycle, as in Timing.

## Test plan
- Reset, with memory always ready and 1-cycle latency, `id_ready = 1`: requests go to 0x0, 0x4, 0x8, …; `if_pc` shows 0x0, 0x4, 0x8 on consecutive cycles; the stage sustains one instruction per cycle.
- `id_ready = 0` held, FIFO_DEPTH = 4: exactly 4 requests are issued, `imem_req_valid` drops to 0, and `if_pc` stays 0x0. Releasing `id_ready` drains 0x0–0xC in order, and issuing resumes.
- Memory latency 3 with 2 requests in flight; redirect to 0x100 (`redirect_pc = 0x102`): the 2 stale responses are dropped, and the next `if_pc` is 0x100, not 0x8.
- Redirect in the same cycle as a response and an accepted request: both stale words are discarded (`drop = 1` after the edge) and the first visible `if_pc` is the target.
- `fetch_pc = 0xFFFF_FFFC`: the next request address wraps to 0x0000_0000.
- `reset_n` pulled low while the FIFO holds 3 entries: after that edge `if_valid = 0`, and the first request after release is to `RESET_PC`.
